// File: rtl/ballgame_pkg.sv
`default_nettype none
// =============================================================================
// ballgame_pkg : geometry defaults, state encodings, coordinate type, helpers
// Revision     : 1.0
// =============================================================================
package ballgame_pkg;

    localparam int BG_BALL_R    = 10;
    localparam int BG_BALL_STEP = 2;
    localparam int BG_PAD_W     = 100;
    localparam int BG_PAD_H     = 20;
    localparam int BG_PAD_STEP  = 4;
    localparam int BG_BLK_W     = 100;
    localparam int BG_BLK_H     = 40;
    localparam int BG_X_MIN     = 10;
    localparam int BG_X_MAX     = 630;
    localparam int BG_Y_MIN     = 10;
    localparam int BG_Y_MAX     = 470;
    localparam int BG_USER1_Y   = 30;
    localparam int BG_USER2_Y   = 450;
    localparam int BG_BLK1_X    = 160;
    localparam int BG_BLK1_Y    = 200;
    localparam int BG_BLK2_X    = 480;
    localparam int BG_BLK2_Y    = 200;
    localparam int BG_BLK3_X    = 320;
    localparam int BG_BLK3_Y    = 320;
    localparam int BG_SERVE_X   = 320;
    localparam int BG_SERVE_Y   = 240;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_OVER = 2'b10
    } game_state_e;

    typedef enum logic [1:0] {
        PH_WAIT   = 2'b00,
        PH_CALC   = 2'b01,
        PH_COMMIT = 2'b10
    } phase_e;

    // Wide enough that a step past either screen edge stays representable.
    typedef logic signed [11:0] coord_t;

    function automatic coord_t abs_c(input coord_t v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic box_overlap(
        input coord_t cx, input coord_t cy, input coord_t r,
        input coord_t bx, input coord_t by, input coord_t hw, input coord_t hh
    );
        return (cx + r >= bx - hw) && (cx - r <= bx + hw) &&
               (cy + r >= by - hh) && (cy - r <= by + hh);
    endfunction

endpackage
`default_nettype wire

// File: rtl/paddle_ctrl.sv
`default_nettype none
// =============================================================================
// paddle_ctrl : paddle button decode, single-frame step and wall clamp
// Revision    : 1.0
// =============================================================================
module paddle_ctrl
    import ballgame_pkg::*;
#(
    parameter int PAD_W    = BG_PAD_W,
    parameter int PAD_STEP = BG_PAD_STEP,
    parameter int X_MIN    = BG_X_MIN,
    parameter int X_MAX    = BG_X_MAX
) (
    input  logic [9:0] cur_x,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [9:0] next_x
);

    localparam coord_t C_LO   = coord_t'(X_MIN + PAD_W / 2);
    localparam coord_t C_HI   = coord_t'(X_MAX - PAD_W / 2);
    localparam coord_t C_STEP = coord_t'(PAD_STEP);

    coord_t cur_s;
    coord_t moved;

    always_comb begin
        cur_s = coord_t'({2'b00, cur_x});
        moved = cur_s;
        // Both buttons pressed cancel out.
        if (btn_left && !btn_right) begin
            moved = cur_s - C_STEP;
        end else if (btn_right && !btn_left) begin
            moved = cur_s + C_STEP;
        end
        if (moved < C_LO) begin
            moved = C_LO;
        end else if (moved > C_HI) begin
            moved = C_HI;
        end
        next_x = 10'(moved);
    end

endmodule
`default_nettype wire

// File: rtl/ball_game_ctrl.sv
`default_nettype none
// =============================================================================
// ball_game_ctrl : game FSM, per-frame ball/paddle update and collision logic
// Revision       : 1.0
// =============================================================================
module ball_game_ctrl
    import ballgame_pkg::*;
#(
    parameter int BALL_R    = BG_BALL_R,
    parameter int BALL_STEP = BG_BALL_STEP,
    parameter int PAD_W     = BG_PAD_W,
    parameter int PAD_H     = BG_PAD_H,
    parameter int PAD_STEP  = BG_PAD_STEP,
    parameter int BLK_W     = BG_BLK_W,
    parameter int BLK_H     = BG_BLK_H,
    parameter int X_MIN     = BG_X_MIN,
    parameter int X_MAX     = BG_X_MAX,
    parameter int Y_MIN     = BG_Y_MIN,
    parameter int Y_MAX     = BG_Y_MAX,
    parameter int USER1_Y   = BG_USER1_Y,
    parameter int USER2_Y   = BG_USER2_Y,
    parameter int BLK1_X    = BG_BLK1_X,
    parameter int BLK1_Y    = BG_BLK1_Y,
    parameter int BLK2_X    = BG_BLK2_X,
    parameter int BLK2_Y    = BG_BLK2_Y,
    parameter int BLK3_X    = BG_BLK3_X,
    parameter int BLK3_Y    = BG_BLK3_Y
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       u1_left,
    input  logic       u1_right,
    input  logic       u2_left,
    input  logic       u2_right,
    output logic       disp_sel,
    output logic [9:0] ball_xaddr,
    output logic [9:0] ball_yaddr,
    output logic [9:0] user1_xaddr,
    output logic [9:0] user1_yaddr,
    output logic [9:0] user2_xaddr,
    output logic [9:0] user2_yaddr,
    output logic [9:0] block1_xaddr,
    output logic [9:0] block1_yaddr,
    output logic [9:0] block2_xaddr,
    output logic [9:0] block2_yaddr,
    output logic [9:0] block3_xaddr,
    output logic [9:0] block3_yaddr,
    output logic [1:0] game_state,
    output logic       loser
);

    localparam coord_t C_R         = coord_t'(BALL_R);
    localparam coord_t C_STEP      = coord_t'(BALL_STEP);
    localparam coord_t C_PAD_HW    = coord_t'(PAD_W / 2);
    localparam coord_t C_PAD1_EDGE = coord_t'(USER1_Y + PAD_H / 2);
    localparam coord_t C_PAD2_EDGE = coord_t'(USER2_Y - PAD_H / 2);
    localparam coord_t C_X_MIN     = coord_t'(X_MIN);
    localparam coord_t C_X_MAX     = coord_t'(X_MAX);
    localparam coord_t C_Y_MIN     = coord_t'(Y_MIN);
    localparam coord_t C_Y_MAX     = coord_t'(Y_MAX);
    localparam coord_t C_BLK_HW    = coord_t'(BLK_W / 2);
    localparam coord_t C_BLK_HH    = coord_t'(BLK_H / 2);
    localparam coord_t C_B1X       = coord_t'(BLK1_X);
    localparam coord_t C_B1Y       = coord_t'(BLK1_Y);
    localparam coord_t C_B2X       = coord_t'(BLK2_X);
    localparam coord_t C_B2Y       = coord_t'(BLK2_Y);
    localparam coord_t C_B3X       = coord_t'(BLK3_X);
    localparam coord_t C_B3Y       = coord_t'(BLK3_Y);
    localparam logic [9:0] C_SERVE_X = 10'(BG_SERVE_X);
    localparam logic [9:0] C_SERVE_Y = 10'(BG_SERVE_Y);

    game_state_e state_q, state_d;
    phase_e      phase_q, phase_d;
    logic        start_q, start_d;
    logic [9:0]  ball_x_q, ball_x_d;
    logic [9:0]  ball_y_q, ball_y_d;
    logic        dx_neg_q, dx_neg_d;
    logic        dy_neg_q, dy_neg_d;
    logic [9:0]  user1_x_q, user1_x_d;
    logic [9:0]  user2_x_q, user2_x_d;
    coord_t      nx_q, nx_d;
    coord_t      ny_q, ny_d;
    logic [9:0]  pad1_n_q, pad1_n_d;
    logic [9:0]  pad2_n_q, pad2_n_d;
    logic        disp_sel_q, disp_sel_d;
    logic        loser_q, loser_d;

    logic        start_rise;
    logic [9:0]  pad1_next;
    logic [9:0]  pad2_next;
    coord_t      ball_x_s;
    coord_t      ball_y_s;
    coord_t      pad1_s;
    coord_t      pad2_s;
    logic        wall_lo;
    logic        wall_hi;
    logic        hit1;
    logic        hit2;
    logic        blk_hit;
    logic        miss_top;
    logic        miss_bot;
    coord_t      res_x;
    coord_t      res_y;
    logic        res_dx_neg;
    logic        res_dy_neg;

    assign start_rise = start && !start_q;

    paddle_ctrl #(
        .PAD_W    (PAD_W),
        .PAD_STEP (PAD_STEP),
        .X_MIN    (X_MIN),
        .X_MAX    (X_MAX)
    ) u_pad1 (
        .cur_x     (user1_x_q),
        .btn_left  (u1_left),
        .btn_right (u1_right),
        .next_x    (pad1_next)
    );

    paddle_ctrl #(
        .PAD_W    (PAD_W),
        .PAD_STEP (PAD_STEP),
        .X_MIN    (X_MIN),
        .X_MAX    (X_MAX)
    ) u_pad2 (
        .cur_x     (user2_x_q),
        .btn_left  (u2_left),
        .btn_right (u2_right),
        .next_x    (pad2_next)
    );

    // Collision resolution works on the CALC results, including the new paddles.
    always_comb begin
        ball_x_s = coord_t'({2'b00, ball_x_q});
        ball_y_s = coord_t'({2'b00, ball_y_q});
        pad1_s   = coord_t'({2'b00, pad1_n_q});
        pad2_s   = coord_t'({2'b00, pad2_n_q});

        wall_lo  = (nx_q - C_R) <= C_X_MIN;
        wall_hi  = (nx_q + C_R) >= C_X_MAX;
        hit1     = dy_neg_q && ((ny_q - C_R) <= C_PAD1_EDGE) &&
                   (abs_c(nx_q - pad1_s) <= C_PAD_HW);
        hit2     = !dy_neg_q && ((ny_q + C_R) >= C_PAD2_EDGE) &&
                   (abs_c(nx_q - pad2_s) <= C_PAD_HW);
        blk_hit  = box_overlap(nx_q, ny_q, C_R, C_B1X, C_B1Y, C_BLK_HW, C_BLK_HH) ||
                   box_overlap(nx_q, ny_q, C_R, C_B2X, C_B2Y, C_BLK_HW, C_BLK_HH) ||
                   box_overlap(nx_q, ny_q, C_R, C_B3X, C_B3Y, C_BLK_HW, C_BLK_HH);
        miss_top = !(hit1 || hit2) && ((ny_q - C_R) <= C_Y_MIN);
        miss_bot = !(hit1 || hit2) && ((ny_q + C_R) >= C_Y_MAX);

        res_x      = nx_q;
        res_dx_neg = dx_neg_q;
        if (wall_lo) begin
            res_x      = C_X_MIN + C_R;
            res_dx_neg = ~dx_neg_q;
        end else if (wall_hi) begin
            res_x      = C_X_MAX - C_R;
            res_dx_neg = ~dx_neg_q;
        end

        // A paddle bounce consumes the frame's single dy flip.
        res_y      = ny_q;
        res_dy_neg = dy_neg_q;
        if (hit1) begin
            res_y      = C_PAD1_EDGE + C_R;
            res_dy_neg = 1'b0;
        end else if (hit2) begin
            res_y      = C_PAD2_EDGE - C_R;
            res_dy_neg = 1'b1;
        end else if (blk_hit) begin
            res_dy_neg = ~dy_neg_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        start_d    = start;
        ball_x_d   = ball_x_q;
        ball_y_d   = ball_y_q;
        dx_neg_d   = dx_neg_q;
        dy_neg_d   = dy_neg_q;
        user1_x_d  = user1_x_q;
        user2_x_d  = user2_x_q;
        nx_d       = nx_q;
        ny_d       = ny_q;
        pad1_n_d   = pad1_n_q;
        pad2_n_d   = pad2_n_q;
        disp_sel_d = disp_sel_q;
        loser_d    = loser_q;

        case (state_q)
            ST_IDLE: begin
                phase_d = PH_WAIT;
                if (start_rise) begin
                    state_d = ST_PLAY;
                end
            end

            ST_PLAY: begin
                case (phase_q)
                    PH_WAIT: begin
                        if (frame_tick) begin
                            phase_d = PH_CALC;
                        end
                    end
                    PH_CALC: begin
                        nx_d     = dx_neg_q ? (ball_x_s - C_STEP) : (ball_x_s + C_STEP);
                        ny_d     = dy_neg_q ? (ball_y_s - C_STEP) : (ball_y_s + C_STEP);
                        pad1_n_d = pad1_next;
                        pad2_n_d = pad2_next;
                        phase_d  = PH_COMMIT;
                    end
                    PH_COMMIT: begin
                        phase_d   = PH_WAIT;
                        user1_x_d = pad1_n_q;
                        user2_x_d = pad2_n_q;
                        if (miss_top || miss_bot) begin
                            state_d    = ST_OVER;
                            disp_sel_d = 1'b1;
                            loser_d    = miss_bot;
                        end else begin
                            ball_x_d = 10'(res_x);
                            ball_y_d = 10'(res_y);
                            dx_neg_d = res_dx_neg;
                            dy_neg_d = res_dy_neg;
                        end
                    end
                    default: phase_d = PH_WAIT;
                endcase
            end

            ST_OVER: begin
                phase_d = PH_WAIT;
                if (start_rise) begin
                    state_d    = ST_IDLE;
                    disp_sel_d = 1'b0;
                    ball_x_d   = C_SERVE_X;
                    ball_y_d   = C_SERVE_Y;
                    user1_x_d  = C_SERVE_X;
                    user2_x_d  = C_SERVE_X;
                    dx_neg_d   = 1'b0;
                    // Serve toward the player who just missed (user1 is at the top).
                    dy_neg_d   = ~loser_q;
                end
            end

            default: begin
                state_d = ST_IDLE;
                phase_d = PH_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            phase_q    <= PH_WAIT;
            start_q    <= 1'b0;
            ball_x_q   <= C_SERVE_X;
            ball_y_q   <= C_SERVE_Y;
            dx_neg_q   <= 1'b0;
            dy_neg_q   <= 1'b0;
            user1_x_q  <= C_SERVE_X;
            user2_x_q  <= C_SERVE_X;
            nx_q       <= '0;
            ny_q       <= '0;
            pad1_n_q   <= C_SERVE_X;
            pad2_n_q   <= C_SERVE_X;
            disp_sel_q <= 1'b0;
            loser_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            start_q    <= start_d;
            ball_x_q   <= ball_x_d;
            ball_y_q   <= ball_y_d;
            dx_neg_q   <= dx_neg_d;
            dy_neg_q   <= dy_neg_d;
            user1_x_q  <= user1_x_d;
            user2_x_q  <= user2_x_d;
            nx_q       <= nx_d;
            ny_q       <= ny_d;
            pad1_n_q   <= pad1_n_d;
            pad2_n_q   <= pad2_n_d;
            disp_sel_q <= disp_sel_d;
            loser_q    <= loser_d;
        end
    end

    assign disp_sel     = disp_sel_q;
    assign game_state   = state_q;
    assign loser        = loser_q;
    assign ball_xaddr   = ball_x_q;
    assign ball_yaddr   = ball_y_q;
    assign user1_xaddr  = user1_x_q;
    assign user1_yaddr  = 10'(USER1_Y);
    assign user2_xaddr  = user2_x_q;
    assign user2_yaddr  = 10'(USER2_Y);
    assign block1_xaddr = 10'(BLK1_X);
    assign block1_yaddr = 10'(BLK1_Y);
    assign block2_xaddr = 10'(BLK2_X);
    assign block2_yaddr = 10'(BLK2_Y);
    assign block3_xaddr = 10'(BLK3_X);
    assign block3_yaddr = 10'(BLK3_Y);

endmodule
`default_nettype wire

// File: tb/tb_ball_game_ctrl.sv
`default_nettype none
// =============================================================================
// tb_ball_game_ctrl : directed trajectory vectors for ball_game_ctrl
// Revision          : 1.0
// =============================================================================
module tb_ball_game_ctrl;

    logic       clk;
    logic       rst_n;
    logic       frame_tick;
    logic       start;
    logic       u1_left, u1_right, u2_left, u2_right;
    logic       disp_sel;
    logic [9:0] ball_xaddr, ball_yaddr;
    logic [9:0] user1_xaddr, user1_yaddr, user2_xaddr, user2_yaddr;
    logic [9:0] block1_xaddr, block1_yaddr, block2_xaddr, block2_yaddr;
    logic [9:0] block3_xaddr, block3_yaddr;
    logic [1:0] game_state;
    logic       loser;

    int errors = 0;
    int checks = 0;
    int ticks  = 0;

    typedef struct {
        int tick;
        int bx;
        int by;
        int u1;
        int u2;
        int gs;
        int disp;
        int los;
    } vec_t;

    localparam int NV = 16;
    vec_t tbl [NV];

    ball_game_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .start        (start),
        .u1_left      (u1_left),
        .u1_right     (u1_right),
        .u2_left      (u2_left),
        .u2_right     (u2_right),
        .disp_sel     (disp_sel),
        .ball_xaddr   (ball_xaddr),
        .ball_yaddr   (ball_yaddr),
        .user1_xaddr  (user1_xaddr),
        .user1_yaddr  (user1_yaddr),
        .user2_xaddr  (user2_xaddr),
        .user2_yaddr  (user2_yaddr),
        .block1_xaddr (block1_xaddr),
        .block1_yaddr (block1_yaddr),
        .block2_xaddr (block2_xaddr),
        .block2_yaddr (block2_yaddr),
        .block3_xaddr (block3_xaddr),
        .block3_yaddr (block3_yaddr),
        .game_state   (game_state),
        .loser        (loser)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_ball(input string tag, input int bx, input int by);
        chk({tag, "_bx"}, int'(ball_xaddr), bx);
        chk({tag, "_by"}, int'(ball_yaddr), by);
    endtask

    // Frame pulse, then enough idle cycles for CALC and COMMIT to finish.
    task automatic pulse_tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic press_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    initial begin
        // tick, ball x, ball y, user1 x, user2 x, state, disp_sel, loser
        tbl[0]  = '{1,   322, 242, 320, 324, 1, 0, 0};
        tbl[1]  = '{10,  340, 260, 320, 360, 1, 0, 0};
        tbl[2]  = '{25,  370, 290, 320, 420, 1, 0, 0};  // block3 top edge touch
        tbl[3]  = '{26,  372, 288, 320, 424, 1, 0, 0};
        tbl[4]  = '{55,  430, 230, 320, 540, 1, 0, 0};  // block2 bottom-left corner
        tbl[5]  = '{56,  432, 232, 320, 544, 1, 0, 0};
        tbl[6]  = '{65,  450, 250, 320, 580, 1, 0, 0};  // user2 clamps at 580
        tbl[7]  = '{100, 520, 320, 320, 580, 1, 0, 0};
        tbl[8]  = '{150, 620, 420, 320, 580, 1, 0, 0};  // right wall
        tbl[9]  = '{151, 618, 422, 320, 580, 1, 0, 0};
        tbl[10] = '{155, 610, 430, 320, 580, 1, 0, 0};  // user2 paddle bounce
        tbl[11] = '{156, 608, 428, 320, 580, 1, 0, 0};
        tbl[12] = '{300, 320, 140, 320, 580, 1, 0, 0};
        tbl[13] = '{359, 202, 22,  320, 580, 1, 0, 0};
        tbl[14] = '{360, 202, 22,  320, 580, 2, 1, 0};  // user1 misses, ball frozen
        tbl[15] = '{361, 202, 22,  320, 580, 2, 1, 0};

        rst_n = 1'b0; frame_tick = 1'b0; start = 1'b0;
        u1_left = 1'b0; u1_right = 1'b0; u2_left = 1'b0; u2_right = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_state", int'(game_state), 0);
        chk("rst_disp", int'(disp_sel), 0);
        chk("rst_loser", int'(loser), 0);
        chk_ball("rst", 320, 240);
        chk("rst_u1x", int'(user1_xaddr), 320);
        chk("rst_u1y", int'(user1_yaddr), 30);
        chk("rst_u2x", int'(user2_xaddr), 320);
        chk("rst_u2y", int'(user2_yaddr), 450);
        chk("rst_b1x", int'(block1_xaddr), 160);
        chk("rst_b1y", int'(block1_yaddr), 200);
        chk("rst_b2x", int'(block2_xaddr), 480);
        chk("rst_b2y", int'(block2_yaddr), 200);
        chk("rst_b3x", int'(block3_xaddr), 320);
        chk("rst_b3y", int'(block3_yaddr), 320);

        // Game 1: user2 holds right the whole time; frames in IDLE do nothing.
        u2_right = 1'b1;
        pulse_tick();
        chk_ball("idle_tick", 320, 240);
        chk("idle_tick_u2x", int'(user2_xaddr), 320);
        chk("idle_tick_state", int'(game_state), 0);

        press_start();
        chk("start_state", int'(game_state), 1);

        // First frame: nothing moves after the CALC edge, update on COMMIT edge.
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        @(negedge clk);
        chk_ball("lat_calc", 320, 240);
        @(negedge clk);
        chk_ball("lat_commit", 322, 242);
        repeat (2) @(negedge clk);
        ticks = 1;

        for (int i = 0; i < NV; i++) begin
            while (ticks < tbl[i].tick) begin
                pulse_tick();
                ticks++;
            end
            chk_ball($sformatf("g1_t%0d", tbl[i].tick), tbl[i].bx, tbl[i].by);
            chk($sformatf("g1_t%0d_u1x", tbl[i].tick), int'(user1_xaddr), tbl[i].u1);
            chk($sformatf("g1_t%0d_u2x", tbl[i].tick), int'(user2_xaddr), tbl[i].u2);
            chk($sformatf("g1_t%0d_state", tbl[i].tick), int'(game_state), tbl[i].gs);
            chk($sformatf("g1_t%0d_disp", tbl[i].tick), int'(disp_sel), tbl[i].disp);
            chk($sformatf("g1_t%0d_loser", tbl[i].tick), int'(loser), tbl[i].los);
        end

        // OVER -> IDLE restores the serve; user1 lost so the next serve goes up.
        u2_right = 1'b0;
        press_start();
        chk("over_idle_state", int'(game_state), 0);
        chk("over_idle_disp", int'(disp_sel), 0);
        chk_ball("over_idle", 320, 240);
        chk("over_idle_u1x", int'(user1_xaddr), 320);
        chk("over_idle_u2x", int'(user2_xaddr), 320);

        press_start();
        chk("g2_state", int'(game_state), 1);

        u1_left = 1'b1; u1_right = 1'b1;
        for (int t = 1; t <= 5; t++) pulse_tick();
        chk_ball("g2_t5", 330, 230);
        chk("g2_t5_both_u1x", int'(user1_xaddr), 320);

        u1_right = 1'b0;
        for (int t = 6; t <= 20; t++) pulse_tick();
        chk_ball("g2_t20", 360, 200);
        chk("g2_t20_u1x", int'(user1_xaddr), 260);
        for (int t = 21; t <= 80; t++) pulse_tick();
        chk_ball("g2_t80", 480, 80);
        chk("g2_t80_u1x", int'(user1_xaddr), 60);

        // Frame pulse held for two cycles: second cycle lands in CALC, ignored.
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk);
        @(negedge clk) frame_tick = 1'b0;
        repeat (4) @(negedge clk);
        chk_ball("g2_dbl_tick", 482, 78);
        chk("g2_dbl_tick_u1x", int'(user1_xaddr), 60);

        // Reset asserted between the CALC and COMMIT edges.
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("midrst_state", int'(game_state), 0);
        chk_ball("midrst", 320, 240);
        chk("midrst_u1x", int'(user1_xaddr), 320);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        u1_left = 1'b0;
        repeat (4) @(negedge clk);
        chk("postrst_state", int'(game_state), 0);
        chk_ball("postrst", 320, 240);

        press_start();
        pulse_tick();
        chk_ball("postrst_t1", 322, 242);
        chk("postrst_t1_state", int'(game_state), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
